ddr_rd_master: RTL and testbench

DDR_RD_MASTER -- requirements
Module: ddr_rd_master

---
 rtl/ddr_rd_master.sv | 143 ++++++++++++++
 tb/tb_ddr_rd_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_master.sv
// AXI4 read master: splits a byte-length read request into INCR bursts that never
// cross a 4 KB page, and streams each returned beat to the checker as rd_en/rd_data.
module ddr_rd_master #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk_ps,
  input  logic        rst_n,
  input  logic        rd_start,
  input  logic [31:0] rd_addr,
  input  logic [31:0] rd_length,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_finish,
  output logic        rd_busy,
  output logic        rd_err
);

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [29:0] words_q;
  logic [8:0]  beat_cnt;
  logic [7:0]  arlen_q;
  logic        rd_en_q;
  logic        rd_err_q;
  logic [31:0] rd_data_q;
  logic [12:0] page_words;
  logic [12:0] cap;
  logic [8:0]  beats_calc;
  logic        beat;
  logic        last_beat;
  logic        unused_lsbs;

  // Sub-word address/length bits are dropped: transfers are whole 32-bit words.
  assign unused_lsbs = ^{rd_addr[1:0], rd_length[1:0]};

  // Burst size: the smallest of remaining words, MAX_BURST and words left in the 4 KB page.
  always_comb begin
    page_words = (13'h1000 - {1'b0, addr_q[11:0]}) >> 2;
    cap        = (page_words < 13'(MAX_BURST)) ? page_words : 13'(MAX_BURST);
    beats_calc = ({17'b0, cap} < words_q) ? 9'(cap) : 9'(words_q);
  end

  assign beat      = (state == DATA) && m_axi_rvalid;
  assign last_beat = beat && (beat_cnt == 9'd1);

  always_ff @(posedge clk_ps) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_busy       = 1'b0;
    rd_finish     = 1'b0;
    case (state)
      IDLE: if (rd_start) state_nxt = CALC;
      CALC: begin
        rd_busy   = 1'b1;
        state_nxt = (words_q == '0) ? DONE : ADDR;
      end
      ADDR: begin
        rd_busy       = 1'b1;
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = DATA;
      end
      DATA: begin
        rd_busy      = 1'b1;
        m_axi_rready = 1'b1;
        if (last_beat) state_nxt = (words_q == 30'd1) ? DONE : CALC;
      end
      DONE: begin
        rd_finish = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_ps) begin
    if (!rst_n) begin
      addr_q    <= '0;
      words_q   <= '0;
      beat_cnt  <= '0;
      arlen_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_en_q <= beat;
      if (beat) rd_data_q <= m_axi_rdata;
      case (state)
        IDLE: begin
          if (rd_start) begin
            addr_q   <= {rd_addr[31:2], 2'b00};
            words_q  <= rd_length[31:2];
            rd_err_q <= 1'b0;
          end
        end
        CALC: begin
          if (words_q != '0) begin
            beat_cnt <= beats_calc;
            arlen_q  <= 8'(beats_calc - 9'd1);
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt - 9'd1;
            addr_q   <= addr_q + 32'd4;
            words_q  <= words_q - 30'd1;
            // Burst length is owned by the beat count; rlast is only cross-checked.
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_cnt == 9'd1)))
              rd_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign rd_en         = rd_en_q;
  assign rd_data       = rd_data_q;
  assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_ddr_rd_master.sv
// Directed bench for ddr_rd_master: table of whole transfers against a scripted AXI
// slave, plus hand sequences for AR stalls, error flags, busy restarts and mid-burst reset.
module tb_ddr_rd_master;

  logic        clk_ps, rst_n, rd_start;
  logic [31:0] rd_addr, rd_length;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_finish, rd_busy, rd_err;

  ddr_rd_master #(.MAX_BURST(16)) dut (
    .clk_ps(clk_ps), .rst_n(rst_n), .rd_start(rd_start), .rd_addr(rd_addr),
    .rd_length(rd_length), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .rd_en(rd_en),
    .rd_data(rd_data), .rd_finish(rd_finish), .rd_busy(rd_busy), .rd_err(rd_err)
  );

  initial begin
    clk_ps = 1'b0;
    forever #5 clk_ps = ~clk_ps;
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk_ps);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic step();
    @(posedge clk_ps);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // ---------------- scripted AXI slave ----------------
  int unsigned ar_stall = 0;
  int unsigned ar_seen = 0;
  bit          gap_en = 0;
  int          err_beat = -1, early_burst = -1, nolast_burst = -1;
  int          burst_idx = -1, gbeat = 0, b_len = 0, b_i = 0;
  bit          r_active = 0;
  logic [31:0] b_addr = '0;
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];

  initial begin
    logic        s_ar, s_r;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    forever begin
      @(negedge clk_ps);
      s_ar   = m_axi_arvalid && m_axi_arready;
      s_r    = m_axi_rvalid && m_axi_rready;
      s_addr = m_axi_araddr;
      s_len  = m_axi_arlen;
      @(posedge clk_ps);
      #1;
      if (s_ar) begin
        ar_addr_log.push_back(s_addr);
        ar_len_log.push_back(s_len);
        b_addr = s_addr; b_len = int'(s_len) + 1; b_i = 0;
        r_active = 1; burst_idx++;
      end else if (s_r && r_active) begin
        b_i++; gbeat++;
        if (b_i == b_len) r_active = 0;
      end
      if (m_axi_arvalid) begin
        m_axi_arready = (ar_seen >= ar_stall);
        ar_seen++;
      end else begin
        m_axi_arready = 1'b0;
        ar_seen = 0;
      end
      m_axi_rvalid = r_active && (!gap_en || ($urandom_range(0, 2) != 0));
      m_axi_rdata  = data_of(b_addr + 32'(4 * b_i));
      m_axi_rlast  = r_active && (((b_i == b_len - 1) && (burst_idx != nolast_burst)) ||
                                  ((b_i == 0) && (b_len > 1) && (burst_idx == early_burst)));
      m_axi_rresp  = (r_active && (gbeat == err_beat)) ? 2'b10 : 2'b00;
    end
  end

  // ---------------- output monitor ----------------
  logic [31:0] got_q[$];
  int   fin_cnt = 0, fin_cyc = 0, fin_beats = 0, busy_cycles = 0, stab_err = 0, start_cyc = 0;
  logic err_at_fin = 1'b0, busy_at_fin = 1'b0;

  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    prev_wait = 1'b0; prev_addr = '0; prev_len = '0;
    forever begin
      @(negedge clk_ps);
      if (rd_en) got_q.push_back(rd_data);
      if (rd_busy) busy_cycles++;
      if (rd_finish) begin
        if (fin_cnt == 0) begin
          fin_cyc = cyc; fin_beats = got_q.size();
          err_at_fin = rd_err; busy_at_fin = rd_busy;
        end
        fin_cnt++;
      end
      if (prev_wait && rst_n &&
          (!m_axi_arvalid || m_axi_araddr != prev_addr || m_axi_arlen != prev_len))
        stab_err++;
      prev_wait = m_axi_arvalid && !m_axi_arready;
      prev_addr = m_axi_araddr;
      prev_len  = m_axi_arlen;
    end
  end

  task automatic clear_stats();
    got_q.delete(); ar_addr_log.delete(); ar_len_log.delete();
    fin_cnt = 0; busy_cycles = 0; stab_err = 0;
    burst_idx = -1; gbeat = 0;
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
    rd_addr = a; rd_length = l; rd_start = 1'b1;
    step();
    start_cyc = cyc;
    rd_start = 1'b0;
  endtask

  task automatic finish_xfer(input string nm);
    for (int k = 0; k < 3000 && fin_cnt == 0; k++) step();
    check({nm, "/finished"}, 64'(fin_cnt > 0), 64'd1);
    repeat (4) step();
  endtask

  task automatic verify(input string nm, input logic [31:0] a, input int beats, input int bursts,
                        input logic [31:0] af, input logic [7:0] lf,
                        input logic [31:0] al, input logic [7:0] ll, input logic ee);
    int mism;
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    check({nm, "/ar_count"}, 64'(ar_addr_log.size()), 64'(bursts));
    if (bursts > 0 && ar_addr_log.size() > 0) begin
      check({nm, "/araddr_first"}, 64'(ar_addr_log[0]), 64'(af));
      check({nm, "/arlen_first"}, 64'(ar_len_log[0]), 64'(lf));
      check({nm, "/araddr_last"}, 64'(ar_addr_log[ar_addr_log.size()-1]), 64'(al));
      check({nm, "/arlen_last"}, 64'(ar_len_log[ar_len_log.size()-1]), 64'(ll));
    end
    check({nm, "/rd_en_count"}, 64'(got_q.size()), 64'(beats));
    mism = 0;
    foreach (got_q[i]) if (got_q[i] !== data_of(base + 32'(4 * i))) mism++;
    check({nm, "/data_mismatches"}, 64'(mism), 64'd0);
    check({nm, "/finish_count"}, 64'(fin_cnt), 64'd1);
    check({nm, "/beats_at_finish"}, 64'(fin_beats), 64'(beats));
    check({nm, "/err_at_finish"}, 64'(err_at_fin), 64'(ee));
    check({nm, "/busy_at_finish"}, 64'(busy_at_fin), 64'd0);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "/flags"},
          64'({m_axi_arvalid, m_axi_rready, rd_en, rd_finish, rd_busy, rd_err, m_axi_arsize, m_axi_arburst}),
          64'({6'b0, 3'b010, 2'b01}));
    check({nm, "/araddr_arlen"}, 64'({m_axi_araddr, m_axi_arlen}), 64'd0);
    check({nm, "/rd_data"}, 64'(rd_data), 64'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          bursts;
    logic [31:0] a_first;
    logic [7:0]  l_first;
    logic [31:0] a_last;
    logic [7:0]  l_last;
    int          beats;
    int          busy_max;
    int          lat_max;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n0;
    vecs[0] = '{32'h1000_0000, 32'd256, 4, 32'h1000_0000, 8'd15, 32'h1000_00C0, 8'd15, 64, 1000, 1000};
    vecs[1] = '{32'h0000_0FF0, 32'd32,  2, 32'h0000_0FF0, 8'd3,  32'h0000_1000, 8'd3,  8,  1000, 1000};
    vecs[2] = '{32'h2222_0000, 32'd0,   0, 32'h0,         8'd0,  32'h0,         8'd0,  0,  1,    3};
    vecs[3] = '{32'h2222_0000, 32'd3,   0, 32'h0,         8'd0,  32'h0,         8'd0,  0,  1,    3};
    vecs[4] = '{32'h0000_0003, 32'd7,   1, 32'h0000_0000, 8'd0,  32'h0000_0000, 8'd0,  1,  1000, 1000};
    vecs[5] = '{32'hFFFF_FFF8, 32'd16,  2, 32'hFFFF_FFF8, 8'd1,  32'h0000_0000, 8'd1,  4,  1000, 1000};
    vecs[6] = '{32'h2000_0100, 32'd84,  2, 32'h2000_0100, 8'd15, 32'h2000_0140, 8'd4,  21, 1000, 1000};
    vecs[7] = '{32'h0000_0FFC, 32'd8,   2, 32'h0000_0FFC, 8'd0,  32'h0000_1000, 8'd0,  2,  1000, 1000};

    rst_n = 1'b0; rd_start = 1'b0; rd_addr = '0; rd_length = '0;
    repeat (3) step();
    @(negedge clk_ps);
    check_reset("reset_state");
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      clear_stats();
      start_xfer(vecs[i].addr, vecs[i].len);
      finish_xfer(nm);
      verify(nm, vecs[i].addr, vecs[i].beats, vecs[i].bursts, vecs[i].a_first, vecs[i].l_first,
             vecs[i].a_last, vecs[i].l_last, 1'b0);
      check({nm, "/busy_cycles_ok"}, 64'(busy_cycles <= vecs[i].busy_max), 64'd1);
      check({nm, "/finish_latency_ok"}, 64'(fin_cyc - start_cyc <= vecs[i].lat_max), 64'd1);
    end

    // AR held off for 10 cycles and gapped R beats
    ar_stall = 10; gap_en = 1;
    clear_stats();
    start_xfer(32'h3000_0000, 32'd128);
    finish_xfer("stall");
    verify("stall", 32'h3000_0000, 32, 2, 32'h3000_0000, 8'd15, 32'h3000_0040, 8'd15, 1'b0);
    check("stall/ar_stable", 64'(stab_err), 64'd0);
    ar_stall = 0; gap_en = 0;

    // SLVERR on the sixth beat; flag must stay set after the transfer
    err_beat = 5;
    clear_stats();
    start_xfer(32'h4000_0000, 32'd128);
    finish_xfer("rresp");
    verify("rresp", 32'h4000_0000, 32, 2, 32'h4000_0000, 8'd15, 32'h4000_0040, 8'd15, 1'b1);
    check("rresp/sticky", 64'(rd_err), 64'd1);
    err_beat = -1;

    // early rlast on second burst, plus a start request while busy
    early_burst = 1;
    clear_stats();
    start_xfer(32'h4000_0000, 32'd128);
    repeat (3) step();
    start_xfer(32'h7000_0000, 32'd4);
    finish_xfer("early_last");
    verify("early_last", 32'h4000_0000, 32, 2, 32'h4000_0000, 8'd15, 32'h4000_0040, 8'd15, 1'b1);
    early_burst = -1;

    clear_stats();
    start_xfer(32'h4000_0000, 32'd64);
    check("clean/err_cleared_on_start", 64'(rd_err), 64'd0);
    finish_xfer("clean");
    verify("clean", 32'h4000_0000, 16, 1, 32'h4000_0000, 8'd15, 32'h4000_0000, 8'd15, 1'b0);

    // final beat of first burst missing rlast
    nolast_burst = 0;
    clear_stats();
    start_xfer(32'h4000_0000, 32'd128);
    finish_xfer("no_last");
    verify("no_last", 32'h4000_0000, 32, 2, 32'h4000_0000, 8'd15, 32'h4000_0040, 8'd15, 1'b1);
    nolast_burst = -1;

    // reset in the middle of a 16-beat burst
    clear_stats();
    start_xfer(32'h5000_0000, 32'd64);
    for (int k = 0; k < 200 && got_q.size() < 6; k++) step();
    check("midrst/reached_beats", 64'(got_q.size() >= 6), 64'd1);
    rst_n = 1'b0;
    step();
    @(negedge clk_ps);
    check_reset("midrst");
    step();
    rst_n = 1'b1;
    n0 = got_q.size();
    repeat (20) step();
    check("midrst/no_finish", 64'(fin_cnt), 64'd0);
    check("midrst/no_more_beats", 64'(got_q.size()), 64'(n0));

    clear_stats();
    start_xfer(32'h5000_0000, 32'd64);
    finish_xfer("after_rst");
    verify("after_rst", 32'h5000_0000, 16, 1, 32'h5000_0000, 8'd15, 32'h5000_0000, 8'd15, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
